// File: rtl/imem_boot_loader_pkg.sv
// Shared types for the instruction-memory boot loader: FSM states and the
// length-header geometry.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    localparam int HDR_BYTES = 2;
    localparam int LEN_W     = 8 * HDR_BYTES;

    // The byte stream is consumed only while a frame is in flight.
    function automatic logic accepts_bytes(input state_e s);
        return (s == S_LEN0) || (s == S_LEN1) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/imem_boot_loader_word_packer.sv
// Assembles four little-endian bytes into a 32-bit word and emits a one-cycle
// registered word_valid strobe together with the held word.
module word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        last_lane,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane_q,       lane_d;
    logic [23:0] shreg_q,      shreg_d;
    logic [31:0] word_q,       word_d;
    logic        word_valid_q, word_valid_d;

    assign last_lane  = (lane_q == 2'd3);
    assign word_valid = word_valid_q;
    assign word       = word_q;

    always_comb begin
        lane_d       = lane_q;
        shreg_d      = shreg_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clr) begin
            lane_d  = 2'd0;
            shreg_d = 24'd0;
        end else if (byte_valid) begin
            // Newest byte enters at the top so byte 0 ends up in bits [7:0].
            lane_d  = lane_q + 2'd1;
            shreg_d = {byte_in, shreg_q[23:8]};
            if (last_lane) begin
                word_valid_d = 1'b1;
                word_d       = {byte_in, shreg_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_q       <= 2'd0;
            shreg_q      <= 24'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            shreg_q      <= shreg_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Fills instruction memory from a framed byte stream (length, data, XOR
// checksum) and releases the core from reset once the image verifies.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              load_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err
);

    state_e              state_q,    state_d;
    logic [7:0]          len_lo_q,   len_lo_d;
    logic [LEN_W-1:0]    len_q,      len_d;
    logic [ADDR_W-1:0]   widx_q,     widx_d;
    logic [7:0]          xor_q,      xor_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                done_q,     done_d;
    logic                err_q,      err_d;
    logic                crst_n_q,   crst_n_d;

    logic                xfer;
    logic                data_xfer;
    logic                pk_clr;
    logic                pk_last_lane;
    logic                pk_word_valid;
    logic [31:0]         pk_word;
    logic [LEN_W-1:0]    n_rx;
    logic                n_too_big;
    logic                word_last;

    assign in_ready  = accepts_bytes(state_q);
    assign xfer      = in_valid & in_ready;
    assign data_xfer = xfer && (state_q == S_DATA);
    assign n_rx      = {in_data, len_lo_q};
    assign n_too_big = (32'(n_rx) > 32'(MAX_WORDS));
    // Compared in 32 bits so the final index of a full-size image cannot wrap.
    assign word_last = ((32'(widx_q) + 32'd1) == 32'(len_q));

    word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (pk_clr),
        .byte_valid (data_xfer),
        .byte_in    (in_data),
        .last_lane  (pk_last_lane),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        widx_d     = widx_q;
        xor_d      = xor_q;
        mem_addr_d = mem_addr_q;
        pk_clr     = 1'b0;
        case (state_q)
            S_LEN0: begin
                if (xfer) begin
                    len_lo_d = in_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    len_d = n_rx;
                    if (n_rx == '0)     state_d = S_CSUM;
                    else if (n_too_big) state_d = S_ERR;
                    else                state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    xor_d = xor_q ^ in_data;
                    if (pk_last_lane) begin
                        // Address is latched here so it lines up with the packer's strobe.
                        mem_addr_d = widx_q;
                        widx_d     = widx_q + 1'b1;
                        if (word_last) state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (load_req) begin
                    state_d = S_LEN0;
                    widx_d  = '0;
                    xor_d   = 8'd0;
                    pk_clr  = 1'b1;
                end
            end
            default: state_d = S_LEN0;
        endcase
        done_d   = (state_d == S_DONE);
        err_d    = (state_d == S_ERR);
        crst_n_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_LEN0;
            len_lo_q   <= 8'd0;
            len_q      <= '0;
            widx_q     <= '0;
            xor_q      <= 8'd0;
            mem_addr_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            crst_n_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            widx_q     <= widx_d;
            xor_q      <= xor_d;
            mem_addr_q <= mem_addr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            crst_n_q   <= crst_n_d;
        end
    end

    assign mem_we    = pk_word_valid;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = pk_word;
    assign cpu_rst_n = crst_n_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued as bytes
// are driven and matched (address, data, cycle) when mem_we fires.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        load_req = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        err;

    imem_boot_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .load_req  (load_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         sb[$];
    wr_t         mon_e;
    logic [31:0] fw[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          wr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                mon_e = sb.pop_front();
                checks += 3;
                if (mem_addr !== mon_e.addr) begin
                    errors++;
                    $display("FAIL wr_addr: got %0d required %0d", mem_addr, mon_e.addr);
                end
                if (mem_wdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL wr_data: got %h required %h", mem_wdata, mon_e.data);
                end
                if (cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL wr_latency: got cycle %0d required %0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    function automatic int pick_gap(input int pct);
        if (int'($urandom_range(0, 99)) < pct) return int'($urandom_range(1, 3));
        return 0;
    endfunction

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit word_end,
                             input logic [9:0] a, input logic [31:0] w);
        bit sent;
        sent = 1'b0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 100 && !sent; t++) begin
            if (in_ready === 1'b1) begin
                if (word_end) sb.push_back('{a, w, cyc + 1});
                sent = 1'b1;
            end
            @(negedge clk);
        end
        if (!sent) begin
            errors++;
            checks++;
            $display("FAIL byte_timeout: in_ready never rose for byte %h", b);
        end
    endtask

    // csum_ov < 0 sends the correct checksum, otherwise the given byte.
    task automatic send_frame(input int gap_pct, input int csum_ov);
        int         n;
        logic [7:0] cs;
        logic [7:0] b;
        n  = fw.size();
        cs = 8'd0;
        send_byte(8'(n), pick_gap(gap_pct), 1'b0, 10'd0, 32'd0);
        send_byte(8'(n >> 8), pick_gap(gap_pct), 1'b0, 10'd0, 32'd0);
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < 4; l++) begin
                b  = fw[i][8*l +: 8];
                cs = cs ^ b;
                send_byte(b, pick_gap(gap_pct), l == 3, 10'(i), fw[i]);
            end
        end
        send_byte((csum_ov < 0) ? cs : 8'(csum_ov), pick_gap(gap_pct), 1'b0, 10'd0, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (mem_we !== 1'b0)     begin errors++; $display("FAIL rst_mem_we: got %b required 0", mem_we); end
        if (mem_addr !== 10'd0)  begin errors++; $display("FAIL rst_mem_addr: got %0d required 0", mem_addr); end
        if (mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_mem_wdata: got %h required 0", mem_wdata); end
        if (cpu_rst_n !== 1'b0)  begin errors++; $display("FAIL rst_cpu_rst_n: got %b required 0", cpu_rst_n); end
        if (done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b required 0", done); end
        if (err !== 1'b0)        begin errors++; $display("FAIL rst_err: got %b required 0", err); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_good_frame();
        int w0;
        w0 = wr_cnt;
        fw.delete();
        fw.push_back(32'h00500093);
        fw.push_back(32'h00100113);
        send_frame(0, -1);
        repeat (3) @(negedge clk);
        checks += 8;
        if (wr_cnt - w0 != 2)          begin errors++; $display("FAIL good_writes: got %0d required 2", wr_cnt - w0); end
        if (done !== 1'b1)             begin errors++; $display("FAIL good_done: got %b required 1", done); end
        if (cpu_rst_n !== 1'b1)        begin errors++; $display("FAIL good_cpu_rst_n: got %b required 1", cpu_rst_n); end
        if (err !== 1'b0)              begin errors++; $display("FAIL good_err: got %b required 0", err); end
        if (in_ready !== 1'b0)         begin errors++; $display("FAIL good_in_ready: got %b required 0", in_ready); end
        if (mem_addr !== 10'd1)        begin errors++; $display("FAIL good_addr_hold: got %0d required 1", mem_addr); end
        if (mem_wdata !== 32'h00100113) begin errors++; $display("FAIL good_data_hold: got %h required 00100113", mem_wdata); end
        if (sb.size() != 0)            begin errors++; $display("FAIL good_sb_drain: got %0d pending required 0", sb.size()); end
        pulse_load_req();
    endtask

    task automatic test_bad_csum();
        fw.delete();
        fw.push_back(32'h00500093);
        fw.push_back(32'h00100113);
        send_frame(0, 0);
        @(negedge clk);
        checks += 4;
        if (err !== 1'b1)       begin errors++; $display("FAIL csum_err: got %b required 1", err); end
        if (done !== 1'b0)      begin errors++; $display("FAIL csum_done: got %b required 0", done); end
        if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL csum_cpu_rst_n: got %b required 0", cpu_rst_n); end
        if (in_ready !== 1'b0)  begin errors++; $display("FAIL csum_in_ready: got %b required 0", in_ready); end
        pulse_load_req();
    endtask

    task automatic test_len_overflow();
        int w0;
        w0 = wr_cnt;
        send_byte(8'h01, 0, 1'b0, 10'd0, 32'd0);
        send_byte(8'h04, 0, 1'b0, 10'd0, 32'd0);
        in_valid = 1'b0;
        checks += 2;
        if (err !== 1'b1)      begin errors++; $display("FAIL len_err: got %b required 1", err); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL len_in_ready: got %b required 0", in_ready); end
        repeat (4) @(negedge clk);
        checks++;
        if (wr_cnt != w0)      begin errors++; $display("FAIL len_no_write: got %0d writes required 0", wr_cnt - w0); end
        pulse_load_req();
    endtask

    task automatic test_empty_and_reload();
        int w0;
        w0 = wr_cnt;
        fw.delete();
        send_frame(0, -1);
        checks += 3;
        if (done !== 1'b1)      begin errors++; $display("FAIL empty_done: got %b required 1", done); end
        if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL empty_cpu_rst_n: got %b required 1", cpu_rst_n); end
        if (wr_cnt != w0)       begin errors++; $display("FAIL empty_writes: got %0d required 0", wr_cnt - w0); end
        pulse_load_req();
        checks += 4;
        if (done !== 1'b0)      begin errors++; $display("FAIL reload_done: got %b required 0", done); end
        if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reload_cpu_rst_n: got %b required 0", cpu_rst_n); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reload_in_ready: got %b required 1", in_ready); end
        if (err !== 1'b0)       begin errors++; $display("FAIL reload_err: got %b required 0", err); end
    endtask

    task automatic test_back_to_back();
        int w0;
        fw.delete();
        for (int i = 0; i < 3; i++) fw.push_back($urandom);
        for (int pass = 0; pass < 2; pass++) begin
            w0 = wr_cnt;
            send_frame(pass == 0 ? 0 : 30, -1);
            @(negedge clk);
            checks += 2;
            if (done !== 1'b1)   begin errors++; $display("FAIL b2b_done pass %0d: got %b required 1", pass, done); end
            if (wr_cnt - w0 != 3) begin errors++; $display("FAIL b2b_writes pass %0d: got %0d required 3", pass, wr_cnt - w0); end
            pulse_load_req();
        end
    endtask

    task automatic test_mid_reset();
        int w0;
        fw.delete();
        fw.push_back(32'hA5A5_1234);
        fw.push_back(32'h0BAD_F00D);
        send_byte(8'h02, 0, 1'b0, 10'd0, 32'd0);
        send_byte(8'h00, 0, 1'b0, 10'd0, 32'd0);
        for (int k = 0; k < 5; k++)
            send_byte(fw[k / 4][8*(k % 4) +: 8], 0, k == 3, 10'd0, fw[0]);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks += 6;
        if (mem_we !== 1'b0)     begin errors++; $display("FAIL mid_mem_we: got %b required 0", mem_we); end
        if (mem_addr !== 10'd0)  begin errors++; $display("FAIL mid_mem_addr: got %0d required 0", mem_addr); end
        if (mem_wdata !== 32'd0) begin errors++; $display("FAIL mid_mem_wdata: got %h required 0", mem_wdata); end
        if (cpu_rst_n !== 1'b0)  begin errors++; $display("FAIL mid_cpu_rst_n: got %b required 0", cpu_rst_n); end
        if (done !== 1'b0)       begin errors++; $display("FAIL mid_done: got %b required 0", done); end
        if (err !== 1'b0)        begin errors++; $display("FAIL mid_err: got %b required 0", err); end
        @(negedge clk);
        rst = 1'b1;
        w0 = wr_cnt;
        repeat (4) @(negedge clk);
        checks += 2;
        if (wr_cnt != w0)   begin errors++; $display("FAIL mid_no_write: got %0d writes required 0", wr_cnt - w0); end
        if (sb.size() != 0) begin errors++; $display("FAIL mid_sb_drain: got %0d pending required 0", sb.size()); end
        fw.delete();
        fw.push_back(32'hCAFE_0001);
        w0 = wr_cnt;
        send_frame(0, -1);
        @(negedge clk);
        checks += 3;
        if (done !== 1'b1)    begin errors++; $display("FAIL fresh_done: got %b required 1", done); end
        if (wr_cnt - w0 != 1) begin errors++; $display("FAIL fresh_writes: got %0d required 1", wr_cnt - w0); end
        if (mem_addr !== 10'd0) begin errors++; $display("FAIL fresh_addr: got %0d required 0", mem_addr); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_len_overflow();
        test_empty_and_reload();
        test_back_to_back();
        test_mid_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL final_sb_drain: got %0d pending required 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
